// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared instruction-format constants and helpers for the fetch/decode front end
package ctrl_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;

  localparam logic [4:0] OPC_HALT = 5'b00000;
  localparam logic [4:0] OPC_NOP  = 5'b00001;

  function automatic logic [4:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return opcode_of(instr) == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - 2-entry FIFO of {instr, pc} between instruction memory and decode
module fetch_buf
  import ctrl_pkg::*;
#(
  parameter int W = INSTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] push_instr,
  input  logic [W-1:0] push_pc,
  output logic [1:0]   count,
  output logic [W-1:0] head_instr,
  output logic [W-1:0] head_pc
);

  logic [W-1:0] e0_instr, e0_pc, e1_instr, e1_pc;
  logic [1:0]   cnt;
  logic         pop_ok, push_ok;

  // Guard against under/overflow even though the issue logic never allows it.
  assign pop_ok  = pop & (cnt != 2'd0);
  assign push_ok = push & ((cnt != 2'd2) | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 2'd0;
      e0_instr <= '0;
      e0_pc    <= '0;
      e1_instr <= '0;
      e1_pc    <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) begin
            e0_instr <= push_instr;
            e0_pc    <= push_pc;
          end else begin
            e1_instr <= push_instr;
            e1_pc    <= push_pc;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0_instr <= e1_instr;
          e0_pc    <= e1_pc;
          cnt      <= cnt - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: head advances, new word lands behind it.
          if (cnt == 2'd1) begin
            e0_instr <= push_instr;
            e0_pc    <= push_pc;
          end else begin
            e0_instr <= e1_instr;
            e0_pc    <= e1_pc;
            e1_instr <= push_instr;
            e1_pc    <= push_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign count      = cnt;
  assign head_instr = e0_instr;
  assign head_pc    = e0_pc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end: PC, imem issue, redirect/discard and halt tracking
module fetch_stage
  import ctrl_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_pc_plus2,
  output logic              halted
);

  logic [DATA_W-1:0] pc, req_pc;
  logic              outstanding, discard, halt_seen, halted_q;
  logic [1:0]        count;
  logic [DATA_W-1:0] head_instr, head_pc;
  logic              pop, flush, push, grant;
  logic [2:0]        occ;

  assign if_valid = (count != 2'd0) & ~halted_q;
  assign pop      = if_valid & ~stall;
  assign flush    = redirect & ~halted_q;

  // Slots already committed (queued + in flight) after this cycle's pop.
  assign occ = {1'b0, count} + {2'b00, outstanding} - {2'b00, pop};

  assign imem_req = rst_n & ~redirect & ~halt_seen & ~halted_q
                  & (~outstanding | imem_rvalid) & (occ < 3'd2);
  assign imem_addr = pc;
  assign grant     = imem_req & imem_gnt;
  assign push      = imem_rvalid & ~discard & ~flush;

  fetch_buf #(.W(DATA_W)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_instr (imem_rdata),
    .push_pc    (req_pc),
    .count      (count),
    .head_instr (head_instr),
    .head_pc    (head_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      halt_seen   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      if (flush) begin
        pc <= redirect_pc;
      end else if (grant) begin
        pc <= pc + DATA_W'(2);
      end

      if (grant) begin
        req_pc <= pc;
      end

      if (grant) begin
        outstanding <= 1'b1;
      end else if (imem_rvalid) begin
        outstanding <= 1'b0;
      end

      // A response still in flight at redirect belongs to the old path.
      if (flush) begin
        discard <= outstanding & ~imem_rvalid;
      end else if (imem_rvalid & discard) begin
        discard <= 1'b0;
      end

      if (flush) begin
        halt_seen <= 1'b0;
      end else if (push & is_halt(imem_rdata)) begin
        halt_seen <= 1'b1;
      end

      if (pop & is_halt(head_instr)) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign if_instr    = head_instr;
  assign if_pc       = head_pc;
  assign if_pc_plus2 = head_pc + DATA_W'(2);
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven bench for fetch_stage with a 1-cycle memory model
module tb_fetch_stage;
  import ctrl_pkg::*;

  logic        clk, rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [15:0] imem_addr, imem_rdata;
  logic        redirect, stall;
  logic [15:0] redirect_pc;
  logic        if_valid, halted;
  logic [15:0] if_instr, if_pc, if_pc_plus2;

  logic        pend, hold_resp, halt_en;
  logic [15:0] paddr;
  int          checks, errors;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        hold;
    logic        ev;
    logic [15:0] epc;
    logic        er;
    logic [15:0] ea;
    logic        eh;
  } vec_t;

  vec_t vq[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a, input logic hen);
    if (hen && a == 16'h0006) return 16'h0000;
    return {OPC_NOP, a[10:0]};
  endfunction

  assign imem_rvalid = pend & ~hold_resp;
  assign imem_rdata  = mem_word(paddr, halt_en);

  fetch_stage #(.DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus2 (if_pc_plus2),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic r, input logic [15:0] rpc,
                              input logic h, input logic ev, input logic [15:0] epc,
                              input logic er, input logic [15:0] ea, input logic eh);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rpc; v.hold = h;
    v.ev = ev; v.epc = epc; v.er = er; v.ea = ea; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: a grant seen before the edge becomes a response in the next cycle.
  task automatic edge_step();
    logic        g, r;
    logic [15:0] a;
    g = imem_req & imem_gnt;
    r = imem_rvalid;
    a = imem_addr;
    @(posedge clk);
    #1;
    if (r) pend = 1'b0;
    if (g) begin
      pend  = 1'b1;
      paddr = a;
    end
  endtask

  task automatic run_cyc(input vec_t v, input string tag);
    stall       = v.stall;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    hold_resp   = v.hold;
    @(negedge clk);
    chk({tag, " if_valid"}, {15'd0, if_valid}, {15'd0, v.ev});
    chk({tag, " imem_req"}, {15'd0, imem_req}, {15'd0, v.er});
    chk({tag, " halted"},   {15'd0, halted},   {15'd0, v.eh});
    if (v.ev) begin
      chk({tag, " if_pc"},       if_pc,       v.epc);
      chk({tag, " if_instr"},    if_instr,    mem_word(v.epc, halt_en));
      chk({tag, " if_pc_plus2"}, if_pc_plus2, v.epc + 16'd2);
    end
    if (v.er) chk({tag, " imem_addr"}, imem_addr, v.ea);
    edge_step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " imem_req"},    {15'd0, imem_req}, 16'd0);
    chk({tag, " if_valid"},    {15'd0, if_valid}, 16'd0);
    chk({tag, " halted"},      {15'd0, halted},   16'd0);
    chk({tag, " if_pc"},       if_pc,             16'h0000);
    chk({tag, " if_instr"},    if_instr,          16'h0000);
    chk({tag, " if_pc_plus2"}, if_pc_plus2,       16'h0002);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; imem_gnt = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
    stall = 1'b0; pend = 1'b0; paddr = 16'h0000; hold_resp = 1'b0; halt_en = 1'b0;

    // Streaming from reset (c0..c5), stall for 5 cycles with head 0x0008 (c6..c10), release.
    vq.push_back(mk(0, 0, 16'h0, 0, 0, 16'h0000, 1, 16'h0000, 0));
    vq.push_back(mk(0, 0, 16'h0, 0, 0, 16'h0000, 1, 16'h0002, 0));
    vq.push_back(mk(0, 0, 16'h0, 0, 1, 16'h0000, 1, 16'h0004, 0));
    vq.push_back(mk(0, 0, 16'h0, 0, 1, 16'h0002, 1, 16'h0006, 0));
    vq.push_back(mk(0, 0, 16'h0, 0, 1, 16'h0004, 1, 16'h0008, 0));
    vq.push_back(mk(0, 0, 16'h0, 0, 1, 16'h0006, 1, 16'h000A, 0));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(1, 0, 16'h0, 0, 1, 16'h0008, 0, 16'h0000, 0));
    vq.push_back(mk(0, 0, 16'h0, 0, 1, 16'h0008, 1, 16'h000C, 0));
    vq.push_back(mk(0, 0, 16'h0, 0, 1, 16'h000A, 1, 16'h000E, 0));
    vq.push_back(mk(0, 0, 16'h0, 0, 1, 16'h000C, 1, 16'h0010, 0));
    // Redirect to 0x0100 while the 0x0010 request is in flight and its response is held back.
    vq.push_back(mk(0, 1, 16'h0100, 1, 1, 16'h000E, 0, 16'h0000, 0));
    vq.push_back(mk(0, 0, 16'h0,    1, 0, 16'h0000, 0, 16'h0000, 0));
    vq.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0000, 1, 16'h0100, 0));
    vq.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0000, 1, 16'h0102, 0));
    vq.push_back(mk(0, 0, 16'h0,    0, 1, 16'h0100, 1, 16'h0104, 0));
    // Redirect to 0x0200 in the same cycle as the 0x0104 response.
    vq.push_back(mk(0, 1, 16'h0200, 0, 1, 16'h0102, 0, 16'h0000, 0));
    vq.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0000, 1, 16'h0200, 0));
    vq.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0000, 1, 16'h0202, 0));
    vq.push_back(mk(0, 0, 16'h0,    0, 1, 16'h0200, 1, 16'h0204, 0));
    // Halt: redirect to 0, memory returns 0x0000 at 0x0006 (index 23 onward).
    vq.push_back(mk(0, 1, 16'h0000, 0, 1, 16'h0202, 0, 16'h0000, 0));
    vq.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0000, 1, 16'h0000, 0));
    vq.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0000, 1, 16'h0002, 0));
    vq.push_back(mk(0, 0, 16'h0,    0, 1, 16'h0000, 1, 16'h0004, 0));
    vq.push_back(mk(0, 0, 16'h0,    0, 1, 16'h0002, 1, 16'h0006, 0));
    vq.push_back(mk(0, 0, 16'h0,    0, 1, 16'h0004, 1, 16'h0008, 0));
    vq.push_back(mk(0, 0, 16'h0,    0, 1, 16'h0006, 0, 16'h0000, 0));
    vq.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0000, 0, 16'h0000, 1));
    vq.push_back(mk(0, 1, 16'h0300, 0, 0, 16'h0000, 0, 16'h0000, 1));
    vq.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0000, 0, 16'h0000, 1));

    #12;
    chk_reset("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      if (i == 23) halt_en = 1'b1;
      run_cyc(vq[i], $sformatf("c%0d", i));
    end

    // Reset out of the halted state clears everything.
    rst_n = 1'b0; pend = 1'b0; halt_en = 1'b0; redirect = 1'b0;
    #1;
    chk_reset("rst_halted");
    edge_step();
    edge_step();
    rst_n = 1'b1;

    // Restart at RESET_PC with grant withheld: address must hold.
    imem_gnt = 1'b0;
    run_cyc(mk(0, 0, 16'h0, 0, 0, 16'h0000, 1, 16'h0000, 0), "e0");
    run_cyc(mk(0, 0, 16'h0, 0, 0, 16'h0000, 1, 16'h0000, 0), "e1");
    imem_gnt = 1'b1;
    run_cyc(mk(0, 0, 16'h0,    0, 0, 16'h0000, 1, 16'h0000, 0), "e2");
    run_cyc(mk(0, 0, 16'h0,    0, 0, 16'h0000, 1, 16'h0002, 0), "e3");
    run_cyc(mk(0, 1, 16'hFFFE, 0, 1, 16'h0000, 0, 16'h0000, 0), "e4");
    run_cyc(mk(0, 0, 16'h0,    0, 0, 16'h0000, 1, 16'hFFFE, 0), "e5");
    run_cyc(mk(0, 0, 16'h0,    0, 0, 16'h0000, 1, 16'h0000, 0), "e6");
    run_cyc(mk(0, 0, 16'h0,    0, 1, 16'hFFFE, 1, 16'h0002, 0), "e7");

    // Reset with the 0x0002 request in flight.
    rst_n = 1'b0; pend = 1'b0;
    #1;
    chk_reset("rst_mid");
    edge_step();
    rst_n = 1'b1;
    run_cyc(mk(0, 0, 16'h0, 0, 0, 16'h0000, 1, 16'h0000, 0), "f0");
    run_cyc(mk(0, 0, 16'h0, 0, 0, 16'h0000, 1, 16'h0002, 0), "f1");
    run_cyc(mk(0, 0, 16'h0, 0, 1, 16'h0000, 1, 16'h0004, 0), "f2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
